// File: rtl/tlp_xcvr_pkg.sv
// Shared types and constants for the CPU->FPGA chunk path of the TLP transceiver.
package tlp_xcvr_pkg;

  localparam int C2F_PTR_NBITS = 3;
  localparam int C2F_OFS_NBITS = 4;

  typedef logic [C2F_PTR_NBITS-1:0] C2FChunkPtr;
  typedef logic [C2F_OFS_NBITS-1:0] C2FChunkOffset;
  typedef logic [C2F_PTR_NBITS:0]   C2FOccupancy;
  typedef logic [7:0]               ByteMask64;
  typedef logic [63:0]              uint64;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } C2FWriterState;

endpackage

// File: rtl/c2f_ring_ctr.sv
// Ring bookkeeping for a chunk ring: committed and acknowledged chunk counts,
// from which the write pointer, read pointer and occupancy are derived.
// The counts are one bit wider than the pointers, so their difference is the
// true occupancy even when the pointers themselves have wrapped.
module c2f_ring_ctr
  import tlp_xcvr_pkg::*;
#(
  parameter int PTR_NBITS = C2F_PTR_NBITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 commit_i,
  input  logic                 ack_i,
  output logic [PTR_NBITS-1:0] wrPtr_o,
  output logic [PTR_NBITS-1:0] rdPtr_o,
  output logic [PTR_NBITS:0]   occupancy_o,
  output logic [PTR_NBITS:0]   occNext_o,
  output logic                 underflow_o
);

  localparam logic [PTR_NBITS:0] CNT_ONE = {{PTR_NBITS{1'b0}}, 1'b1};

  logic [PTR_NBITS:0] commitCnt_q, commitCnt_d;
  logic [PTR_NBITS:0] ackCnt_q, ackCnt_d;
  logic               ackOk;

  // Advance the counts; an ack against an empty ring is refused and reported.
  always_comb begin
    ackOk       = ack_i && (occupancy_o != '0);
    underflow_o = ack_i && (occupancy_o == '0);
    commitCnt_d = commitCnt_q;
    ackCnt_d    = ackCnt_q;
    if (commit_i) begin
      commitCnt_d = commitCnt_q + CNT_ONE;
    end
    if (ackOk) begin
      ackCnt_d = ackCnt_q + CNT_ONE;
    end
    occNext_o = commitCnt_d - ackCnt_d;
  end

  // Hold the counts; reset empties the ring.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commitCnt_q <= '0;
      ackCnt_q    <= '0;
    end else begin
      commitCnt_q <= commitCnt_d;
      ackCnt_q    <= ackCnt_d;
    end
  end

  assign wrPtr_o     = commitCnt_q[PTR_NBITS-1:0];
  assign rdPtr_o     = ackCnt_q[PTR_NBITS-1:0];
  assign occupancy_o = commitCnt_q - ackCnt_q;

endmodule

// File: rtl/c2f_chunk_writer.sv
// Writes the CPU->FPGA qword burst stream into the chunk RAM, publishes the
// committed write pointer to the consumer, applies backpressure when the
// ring is full and flags malformed bursts with sticky error bits.
module c2f_chunk_writer
  import tlp_xcvr_pkg::*;
#(
  parameter int PTR_NBITS = C2F_PTR_NBITS,
  parameter int OFS_NBITS = C2F_OFS_NBITS
) (
  input  logic                           sysClk,
  input  logic                           sysReset,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [OFS_NBITS-1:0]           inOffset,
  input  logic [7:0]                     inByteMask,
  input  logic [63:0]                    inData,
  input  logic                           inLast,
  output logic                           ramWrEnable,
  output logic [7:0]                     ramByteMask,
  output logic [PTR_NBITS+OFS_NBITS-1:0] ramAddr,
  output logic [63:0]                    ramData,
  output logic [PTR_NBITS-1:0]           wrPtr,
  input  logic                           dtAck,
  output logic [PTR_NBITS-1:0]           rdPtr,
  output logic [PTR_NBITS:0]             occupancy,
  output logic                           errOrder,
  output logic                           errShort,
  output logic                           errUnderflow,
  input  logic                           errClear
);

  localparam logic [OFS_NBITS-1:0] OFS_LAST = {OFS_NBITS{1'b1}};
  localparam logic [OFS_NBITS-1:0] OFS_ONE  = {{(OFS_NBITS-1){1'b0}}, 1'b1};
  localparam logic [PTR_NBITS:0]   OCC_FULL = {1'b1, {PTR_NBITS{1'b0}}};

  C2FWriterState state_q, state_d;
  logic [OFS_NBITS-1:0] expOfs_q, expOfs_d;
  logic inReady_q, inReady_d;
  logic commitPend_q;
  logic ramWrEnable_q;
  ByteMask64 ramByteMask_q;
  logic [PTR_NBITS+OFS_NBITS-1:0] ramAddr_q;
  uint64 ramData_q;
  logic errOrder_q, errOrder_d;
  logic errShort_q, errShort_d;
  logic errUnderflow_q, errUnderflow_d;

  logic accept;
  logic atFinal;
  logic isLast;
  logic orderBad;
  logic shortBad;
  logic commitNext;
  logic underflow;
  logic [PTR_NBITS-1:0] fillPtr;
  logic [PTR_NBITS:0] occNext;
  logic [PTR_NBITS:0] reserved;

  // The chunk commits one cycle after its last qword is accepted, in step
  // with the RAM write of that qword, so the consumer never sees the pointer
  // move ahead of the data.
  c2f_ring_ctr #(
    .PTR_NBITS(PTR_NBITS)
  ) ringCtr (
    .clk_i      (sysClk),
    .rst_i      (sysReset),
    .commit_i   (commitPend_q),
    .ack_i      (dtAck),
    .wrPtr_o    (wrPtr),
    .rdPtr_o    (rdPtr),
    .occupancy_o(occupancy),
    .occNext_o  (occNext),
    .underflow_o(underflow)
  );

  // Next-state logic: burst tracking, offset checking, error detection and
  // the readiness decision for the following cycle.
  always_comb begin
    accept     = inValid && inReady_q;
    atFinal    = (expOfs_q == OFS_LAST);
    isLast     = inLast || atFinal;
    orderBad   = accept && (inOffset != expOfs_q);
    shortBad   = accept && (inLast != atFinal);
    commitNext = accept && isLast;
    // A chunk that starts while the previous one is still committing belongs
    // to the slot after the not-yet-advanced write pointer.
    fillPtr    = wrPtr + {{(PTR_NBITS-1){1'b0}}, commitPend_q};
    state_d    = state_q;
    expOfs_d   = expOfs_q;
    if (accept) begin
      if (isLast) begin
        state_d  = S_IDLE;
        expOfs_d = '0;
      end else begin
        state_d  = S_BURST;
        expOfs_d = expOfs_q + OFS_ONE;
      end
    end
    // A chunk whose commit is still in flight already owns a ring slot.
    reserved       = occNext + {{PTR_NBITS{1'b0}}, commitNext};
    inReady_d      = (state_d == S_BURST) || (reserved < OCC_FULL);
    errOrder_d     = (errOrder_q && !errClear) || orderBad;
    errShort_d     = (errShort_q && !errClear) || shortBad;
    errUnderflow_d = (errUnderflow_q && !errClear) || underflow;
  end

  // Burst FSM with its registered outputs: readiness, the one-stage RAM
  // write register, the pending commit and the sticky errors.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q        <= S_IDLE;
      expOfs_q       <= '0;
      inReady_q      <= 1'b0;
      commitPend_q   <= 1'b0;
      ramWrEnable_q  <= 1'b0;
      ramByteMask_q  <= '0;
      ramAddr_q      <= '0;
      ramData_q      <= '0;
      errOrder_q     <= 1'b0;
      errShort_q     <= 1'b0;
      errUnderflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      expOfs_q       <= expOfs_d;
      inReady_q      <= inReady_d;
      commitPend_q   <= commitNext;
      ramWrEnable_q  <= accept;
      if (accept) begin
        ramByteMask_q <= inByteMask;
        ramAddr_q     <= {fillPtr, inOffset};
        ramData_q     <= inData;
      end
      errOrder_q     <= errOrder_d;
      errShort_q     <= errShort_d;
      errUnderflow_q <= errUnderflow_d;
    end
  end

  assign inReady      = inReady_q;
  assign ramWrEnable  = ramWrEnable_q;
  assign ramByteMask  = ramByteMask_q;
  assign ramAddr      = ramAddr_q;
  assign ramData      = ramData_q;
  assign errOrder     = errOrder_q;
  assign errShort     = errShort_q;
  assign errUnderflow = errUnderflow_q;

endmodule

// File: tb/tb_c2f_chunk_writer.sv
// Bench for c2f_chunk_writer: directed bursts, a chunk-level reference model
// compared on every falling edge, and literal checks at key points.
module tb_c2f_chunk_writer;

  logic       sysClk = 1'b0;
  logic       sysReset;
  logic       inValid;
  logic       inReady;
  logic [3:0] inOffset;
  logic [7:0] inByteMask;
  logic [63:0] inData;
  logic       inLast;
  logic       ramWrEnable;
  logic [7:0] ramByteMask;
  logic [6:0] ramAddr;
  logic [63:0] ramData;
  logic [2:0] wrPtr;
  logic       dtAck;
  logic [2:0] rdPtr;
  logic [3:0] occupancy;
  logic       errOrder;
  logic       errShort;
  logic       errUnderflow;
  logic       errClear;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Reference model state: chunks whose last qword was accepted, chunks
  // visible to the consumer, chunks acknowledged.
  int mFinished = 0;
  int mCommitted = 0;
  int mAcked = 0;
  int mExp = 0;
  bit mPending = 0;
  bit mBurst = 0;
  bit mReady = 0;
  bit mWrEn = 0;
  logic [6:0] mAddr = '0;
  logic [63:0] mData = '0;
  logic [7:0] mMask = '0;
  bit mErrO = 0, mErrS = 0, mErrU = 0;
  bit mAcc, mLastQ, nO, nS, nU;
  int mOcc;

  always #5 sysClk = ~sysClk;

  c2f_chunk_writer dut (
    .sysClk      (sysClk),
    .sysReset    (sysReset),
    .inValid     (inValid),
    .inReady     (inReady),
    .inOffset    (inOffset),
    .inByteMask  (inByteMask),
    .inData      (inData),
    .inLast      (inLast),
    .ramWrEnable (ramWrEnable),
    .ramByteMask (ramByteMask),
    .ramAddr     (ramAddr),
    .ramData     (ramData),
    .wrPtr       (wrPtr),
    .dtAck       (dtAck),
    .rdPtr       (rdPtr),
    .occupancy   (occupancy),
    .errOrder    (errOrder),
    .errShort    (errShort),
    .errUnderflow(errUnderflow),
    .errClear    (errClear)
  );

  function automatic logic [63:0] seq64(int tag, int i);
    return {32'hC2F0_0000 | 32'(tag), 32'hD000_0000 | 32'(i)};
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: one update per rising edge from the stimulus alone.
  always @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      mFinished = 0; mCommitted = 0; mAcked = 0; mExp = 0;
      mPending = 0; mBurst = 0; mReady = 0; mWrEn = 0;
      mAddr = '0; mData = '0; mMask = '0;
      mErrO = 0; mErrS = 0; mErrU = 0;
    end else begin
      mAcc = inValid && mReady;
      mOcc = mCommitted - mAcked;
      nU = dtAck && (mOcc == 0);
      nO = 0;
      nS = 0;
      if (mPending) mCommitted++;
      if (dtAck && mOcc > 0) mAcked++;
      mPending = 0;
      mWrEn = mAcc;
      if (mAcc) begin
        mAddr = 7'((mFinished % 8) * 16 + int'(inOffset));
        mData = inData;
        mMask = inByteMask;
        nO = (int'(inOffset) != mExp);
        mLastQ = inLast || (mExp == 15);
        nS = (inLast != (mExp == 15));
        if (mLastQ) begin
          mFinished++;
          mPending = 1;
          mExp = 0;
          mBurst = 0;
        end else begin
          mExp++;
          mBurst = 1;
        end
      end
      mErrO = (mErrO && !errClear) || nO;
      mErrS = (mErrS && !errClear) || nS;
      mErrU = (mErrU && !errClear) || nU;
      mReady = mBurst || ((mFinished - mAcked) < 8);
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge sysClk) begin
    if (checkEn) begin
      checkOutput("inReady", 64'(inReady), 64'(mReady));
      checkOutput("ramWrEnable", 64'(ramWrEnable), 64'(mWrEn));
      if (mWrEn) begin
        checkOutput("ramAddr", 64'(ramAddr), 64'(mAddr));
        checkOutput("ramData", ramData, mData);
        checkOutput("ramByteMask", 64'(ramByteMask), 64'(mMask));
      end
      checkOutput("wrPtr", 64'(wrPtr), 64'(mCommitted % 8));
      checkOutput("rdPtr", 64'(rdPtr), 64'(mAcked % 8));
      checkOutput("occupancy", 64'(occupancy), 64'(mCommitted - mAcked));
      checkOutput("errOrder", 64'(errOrder), 64'(mErrO));
      checkOutput("errShort", 64'(errShort), 64'(mErrS));
      checkOutput("errUnderflow", 64'(errUnderflow), 64'(mErrU));
    end
  end

  // Present one qword at a falling edge and hold it until it is accepted.
  task automatic applyStimulus(int ofs, logic [63:0] data, logic [7:0] mask, bit last);
    int tries = 0;
    inValid    = 1'b1;
    inOffset   = 4'(ofs);
    inData     = data;
    inByteMask = mask;
    inLast     = last;
    while (!inReady && tries < 100) begin
      @(negedge sysClk);
      tries++;
    end
    vectors++;
    if (tries >= 100) begin
      miscompares++;
      $display("[TB] FAIL acceptTimeout: waited %0d cycles, required fewer than 100", tries);
    end
    @(negedge sysClk);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic sendChunk(int tag);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, seq64(tag, i), 8'hFF ^ 8'(i), i == 15);
    end
  endtask

  task automatic idleCycles(int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic ackPulse();
    dtAck = 1'b1;
    @(negedge sysClk);
    dtAck = 1'b0;
  endtask

  task automatic clearPulse();
    errClear = 1'b1;
    @(negedge sysClk);
    errClear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int errOfs [9];
    sysReset = 1'b1;
    inValid = 1'b0;
    inOffset = '0;
    inByteMask = '0;
    inData = '0;
    inLast = 1'b0;
    dtAck = 1'b0;
    errClear = 1'b0;

    // Reset state
    #1;
    checkOutput("rstInReady", 64'(inReady), 64'd0);
    checkOutput("rstRamWrEnable", 64'(ramWrEnable), 64'd0);
    checkOutput("rstOccupancy", 64'(occupancy), 64'd0);
    checkOutput("rstWrPtr", 64'(wrPtr), 64'd0);
    idleCycles(2);
    checkEn = 1'b1;
    sysReset = 1'b0;
    idleCycles(1);
    checkOutput("postRstInReady", 64'(inReady), 64'd1);

    // First full chunk into slot 0
    sendChunk(1);
    checkOutput("c1LastWrEn", 64'(ramWrEnable), 64'd1);
    checkOutput("c1LastAddr", 64'(ramAddr), 64'd15);
    checkOutput("c1LastData", ramData, 64'hC2F0_0001_D000_000F);
    checkOutput("c1WrPtrBeforeCommit", 64'(wrPtr), 64'd0);
    idleCycles(1);
    checkOutput("c1WrPtr", 64'(wrPtr), 64'd1);
    checkOutput("c1Occupancy", 64'(occupancy), 64'd1);
    checkOutput("c1ErrShort", 64'(errShort), 64'd0);

    // Fill the ring without acks
    for (int t = 2; t <= 8; t++) sendChunk(t);
    idleCycles(1);
    checkOutput("fullOccupancy", 64'(occupancy), 64'd8);
    checkOutput("fullWrPtr", 64'(wrPtr), 64'd0);
    checkOutput("fullInReady", 64'(inReady), 64'd0);

    // A ninth chunk start is held off
    inValid = 1'b1;
    inOffset = 4'd0;
    inData = seq64(99, 0);
    inByteMask = 8'hFF;
    idleCycles(3);
    checkOutput("blockedWrEn", 64'(ramWrEnable), 64'd0);
    checkOutput("blockedInReady", 64'(inReady), 64'd0);
    inValid = 1'b0;
    ackPulse();
    checkOutput("ackOccupancy", 64'(occupancy), 64'd7);
    checkOutput("ackRdPtr", 64'(rdPtr), 64'd1);
    checkOutput("ackInReady", 64'(inReady), 64'd1);

    // Drain to 3, then commit and ack on the same edge
    repeat (4) ackPulse();
    checkOutput("drainOccupancy", 64'(occupancy), 64'd3);
    sendChunk(9);
    dtAck = 1'b1;
    @(negedge sysClk);
    dtAck = 1'b0;
    checkOutput("sameEdgeOccupancy", 64'(occupancy), 64'd3);
    checkOutput("sameEdgeRdPtr", 64'(rdPtr), 64'd6);
    checkOutput("sameEdgeWrPtr", 64'(wrPtr), 64'd1);

    // Skipped offset and early inLast into slot 1
    errOfs = '{0, 1, 3, 4, 5, 6, 7, 8, 9};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(errOfs[i], seq64(10, errOfs[i]), 8'h0F, i == 8);
      if (i == 2) begin
        checkOutput("skipAddr", 64'(ramAddr), 64'd19);
        checkOutput("skipErrOrder", 64'(errOrder), 64'd1);
        checkOutput("skipErrShort", 64'(errShort), 64'd0);
      end
    end
    checkOutput("earlyLastErrShort", 64'(errShort), 64'd1);
    idleCycles(1);
    checkOutput("earlyLastWrPtr", 64'(wrPtr), 64'd2);
    checkOutput("earlyLastOccupancy", 64'(occupancy), 64'd4);
    clearPulse();
    checkOutput("clrErrOrder", 64'(errOrder), 64'd0);
    checkOutput("clrErrShort", 64'(errShort), 64'd0);

    // Final offset without inLast is forced to close the chunk
    for (int i = 0; i < 16; i++) applyStimulus(i, seq64(11, i), 8'hF0, 1'b0);
    checkOutput("forcedErrShort", 64'(errShort), 64'd1);
    checkOutput("forcedErrOrder", 64'(errOrder), 64'd0);
    idleCycles(1);
    checkOutput("forcedWrPtr", 64'(wrPtr), 64'd3);
    checkOutput("forcedOccupancy", 64'(occupancy), 64'd5);
    clearPulse();

    // Drain completely, then ack an empty ring
    repeat (5) ackPulse();
    checkOutput("emptyOccupancy", 64'(occupancy), 64'd0);
    ackPulse();
    checkOutput("underflowErr", 64'(errUnderflow), 64'd1);
    checkOutput("underflowRdPtr", 64'(rdPtr), 64'd3);
    checkOutput("underflowOccupancy", 64'(occupancy), 64'd0);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) applyStimulus(i, seq64(12, i), 8'hFF, 1'b0);
    checkOutput("midBurstWrEn", 64'(ramWrEnable), 64'd1);
    checkOutput("midBurstAddr", 64'(ramAddr), 64'd52);
    #2;
    sysReset = 1'b1;
    #1;
    checkOutput("midRstWrEn", 64'(ramWrEnable), 64'd0);
    checkOutput("midRstWrPtr", 64'(wrPtr), 64'd0);
    checkOutput("midRstRdPtr", 64'(rdPtr), 64'd0);
    checkOutput("midRstErrUnderflow", 64'(errUnderflow), 64'd0);
    checkOutput("midRstInReady", 64'(inReady), 64'd0);
    idleCycles(2);
    sysReset = 1'b0;
    idleCycles(1);
    sendChunk(13);
    checkOutput("afterRstLastAddr", 64'(ramAddr), 64'd15);
    idleCycles(1);
    checkOutput("afterRstWrPtr", 64'(wrPtr), 64'd1);
    checkOutput("afterRstOccupancy", 64'(occupancy), 64'd1);
    idleCycles(2);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
